// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: one outstanding imem read, a one-entry instruction register toward decode, and redirect handling.
// Data reaches inst one cycle after imem_ack; HOLD keeps the word until inst_ready, and redirect flushes or drains in any state.
module inst_fetch #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_d,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  always_comb begin
    pc_en = 1'b0;
    pc_d  = pc;
    if (!reset) begin
      if (redirect) begin
        pc_en = 1'b1;
        pc_d  = redirect_target;
      end else if (state_q == FETCH && imem_ack) begin
        pc_en = 1'b1;
        pc_d  = pc + PC_STEP;
      end
    end
  end

  // Every entry into FETCH latches pc_d, which already equals pc when pc_en is low.
  always_comb begin
    state_d      = state_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    case (state_q)
      IDLE: begin
        state_d      = FETCH;
        imem_req_d   = 1'b1;
        imem_addr_d  = pc_d;
        inst_valid_d = 1'b0;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            imem_addr_d = pc_d;
          end else begin
            state_d      = HOLD;
            imem_req_d   = 1'b0;
            inst_valid_d = 1'b1;
            inst_d       = imem_rdata;
            inst_pc_d    = imem_addr_q;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect || inst_ready) begin
          state_d      = FETCH;
          imem_req_d   = 1'b1;
          imem_addr_d  = pc_d;
          inst_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        // An ack retires the stale request even when a new redirect arrives with it.
        if (imem_ack) begin
          state_d     = FETCH;
          imem_addr_d = pc_d;
        end
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'd0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: transaction-level reference model plus directed literal checks and randomized traffic.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'd0;
  logic [31:0] pc_d;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_d(pc_d), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  // PC register owned by the environment, reset value 0
  always @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else if (pc_en) pc <= pc_d;
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: is a request outstanding, is its answer unwanted, is a word held for decode
  bit          m_start, m_req, m_disc, m_valid, armed = 1'b0;
  logic [31:0] m_addr, m_inst, m_ipc;
  bit          mem_auto = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic red, input logic [31:0] tgt,
                     input logic ak_in, input logic [31:0] rd, input logic rdy);
    logic        ak;
    logic        e_en;
    logic [31:0] e_d;
    @(posedge clk);
    #1;
    ak = ak_in;
    if (mem_auto) begin
      if (r) begin
        ak = 1'b0;
        mem_busy = 1'b0;
      end else if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_lat = $urandom_range(0, 3);
        end
        if (mem_lat == 0) begin
          ak = 1'b1;
          mem_busy = 1'b0;
        end else begin
          mem_lat--;
          ak = 1'b0;
        end
      end else begin
        mem_busy = 1'b0;
        ak = ($urandom_range(0, 7) == 0);
      end
    end
    reset = r; redirect = red; redirect_target = tgt;
    imem_ack = ak; imem_rdata = rd; inst_ready = rdy;
    #1;
    if (r)                          begin e_en = 1'b0; e_d = pc; end
    else if (red)                   begin e_en = 1'b1; e_d = tgt; end
    else if (m_req && !m_disc && ak) begin e_en = 1'b1; e_d = pc + 32'd4; end
    else                            begin e_en = 1'b0; e_d = pc; end
    chk("pc_en", {31'b0, pc_en}, {31'b0, e_en});
    chk("pc_d", pc_d, e_d);
    if (armed) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("imem_addr", imem_addr, m_addr);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
    end
    if (r) begin
      m_start = 1'b1; m_req = 1'b0; m_disc = 1'b0; m_valid = 1'b0;
      m_addr = 32'd0; m_inst = 32'd0; m_ipc = 32'd0; armed = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0; m_req = 1'b1; m_disc = 1'b0; m_addr = e_d;
    end else if (m_req) begin
      if (ak) begin
        if (!m_disc && !red) begin
          m_valid = 1'b1; m_inst = rd; m_ipc = m_addr; m_req = 1'b0;
        end else begin
          m_disc = 1'b0; m_addr = e_d;
        end
      end else if (red) begin
        m_disc = 1'b1;
      end
    end else if (red || rdy) begin
      m_valid = 1'b0; m_req = 1'b1; m_addr = e_d;
    end
  endtask

  initial begin
    // reset, with a redirect that must be ignored
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h55, 1, 0, 1);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h20020005, 0);
    chk("ack_pc_en", {31'b0, pc_en}, 32'd1);
    chk("ack_pc_d", pc_d, 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 32'hFFFF0000, 0);
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h20020005);
      chk("hold_inst_pc", inst_pc, 32'd0);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      chk("hold_pc_en", {31'b0, pc_en}, 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("next_addr", imem_addr, 32'd4);
    chk("next_req", {31'b0, imem_req}, 32'd1);
    cyc(0, 0, 0, 1, 32'h11111111, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("inst2_pc", inst_pc, 32'd4);
    // redirect in HOLD without ready
    cyc(0, 1, 32'h100, 0, 0, 0);
    chk("rdh_pc_en", {31'b0, pc_en}, 32'd1);
    chk("rdh_pc_d", pc_d, 32'h100);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rdh_valid", {31'b0, inst_valid}, 32'd0);
    chk("rdh_addr", imem_addr, 32'h100);
    // redirect together with ack
    cyc(0, 1, 32'h40, 1, 32'hDEADBEEF, 0);
    chk("rda_pc_d", pc_d, 32'h40);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rda_valid", {31'b0, inst_valid}, 32'd0);
    chk("rda_addr", imem_addr, 32'h40);
    // redirect before ack, then drain
    cyc(0, 1, 32'h200, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h40);
    cyc(0, 0, 0, 1, 32'h0BAD0BAD, 0);
    chk("drain_pc_en", {31'b0, pc_en}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_valid", {31'b0, inst_valid}, 32'd0);
    chk("drain_next", imem_addr, 32'h200);
    // PC wrap at the top of the address space
    cyc(0, 1, 32'hFFFFFFFC, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    cyc(0, 0, 0, 1, 32'hCAFEF00D, 0);
    chk("wrap_pc_d", pc_d, 32'h00000000);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_inst_pc", inst_pc, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_next", imem_addr, 32'd0);
    // reset while draining
    cyc(0, 1, 32'h300, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_rst_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);

    mem_auto = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic        r, red, rdy;
      logic [31:0] tgt, rnd;
      r   = ($urandom_range(0, 249) == 0);
      red = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      rnd = $urandom;
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {rnd[31:2], 2'b00};
      cyc(r, red, tgt, 1'b0, $urandom, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
